// File: rtl/pck_bus.sv
// Shared definitions for the peripheral bus arbiter: FSM state encoding and
// timeout counter width.
package pck_bus;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

  localparam int unsigned TMO_W = 8;

endpackage

// File: rtl/perif_bus_arbiter.sv
// Two-requester round-robin arbiter in front of one peripheral slave port.
// Optional grant timeout enabled by defining PERIF_ARB_TIMEOUT_EN.
module perif_bus_arbiter
  import pck_bus::*;
#(
  parameter int unsigned p_timeout = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [9:2]  i_m0_addr,
  input  logic [3:0]  i_m0_be,
  input  logic        i_m0_wr_en,
  input  logic        i_m0_rd_en,
  input  logic [31:0] i_m0_wr_data,
  output logic [31:0] o_m0_rd_data,
  output logic        o_m0_busy,
  output logic        o_m0_ack,
  input  logic [9:2]  i_m1_addr,
  input  logic [3:0]  i_m1_be,
  input  logic        i_m1_wr_en,
  input  logic        i_m1_rd_en,
  input  logic [31:0] i_m1_wr_data,
  output logic [31:0] o_m1_rd_data,
  output logic        o_m1_busy,
  output logic        o_m1_ack,
`ifdef PERIF_ARB_TIMEOUT_EN
  output logic        o_m0_err,
  output logic        o_m1_err,
`endif
  output logic [9:2]  o_s_addr,
  output logic [3:0]  o_s_be,
  output logic        o_s_wr_en,
  output logic [31:0] o_s_wr_data,
  output logic        o_s_rd_en,
  input  logic [31:0] i_s_rd_data,
  input  logic        i_s_busy,
  input  logic        i_s_ack
);

  arb_state_t state_q, state_d;
  logic       ptr_q, ptr_d;      // last served requester
  logic       owner_q, owner_d;  // last granted requester, steers read data
  logic       req0, req1, gnt0, gnt1, to_hit, done;

  assign req0 = i_m0_wr_en | i_m0_rd_en;
  assign req1 = i_m1_wr_en | i_m1_rd_en;
  assign gnt0 = (state_q == ST_GRANT0);
  assign gnt1 = (state_q == ST_GRANT1);
  // A timeout closes the transfer exactly like a slave ack.
  assign done = (gnt0 | gnt1) & (i_s_ack | to_hit);

`ifdef PERIF_ARB_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(p_timeout - 1);
  logic [TMO_W-1:0] cnt_q, cnt_d;

  assign to_hit = (gnt0 | gnt1) & ~i_s_ack & (cnt_q == TMO_LAST);

  // Grant-cycle counter: cleared whenever a (re)grant starts.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d == ST_IDLE || state_d != state_q || done) cnt_d = '0;
    else if (!i_s_ack) cnt_d = cnt_q + 1'b1;
  end

  // Timeout counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_m0_err = gnt0 & to_hit;
  assign o_m1_err = gnt1 & to_hit;
`else
  logic cfg_unused;
  assign cfg_unused = ^(TMO_W'(p_timeout));
  assign to_hit     = 1'b0;
`endif

  // Next-state, round-robin pointer and owner tracking.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 && req1) state_d = ptr_q ? ST_GRANT0 : ST_GRANT1;
        else if (req0)    state_d = ST_GRANT0;
        else if (req1)    state_d = ST_GRANT1;
      end
      ST_GRANT0: begin
        if (done) begin
          ptr_d = 1'b0;
          if (req1)      state_d = ST_GRANT1;
          else if (req0) state_d = ST_GRANT0;
          else           state_d = ST_IDLE;
        end else if (!req0) begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT1: begin
        if (done) begin
          ptr_d = 1'b1;
          if (req0)      state_d = ST_GRANT0;
          else if (req1) state_d = ST_GRANT1;
          else           state_d = ST_IDLE;
        end else if (!req1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_GRANT0) owner_d = 1'b0;
    if (state_d == ST_GRANT1) owner_d = 1'b1;
  end

  // State, pointer and owner registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b1;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Slave port mux and requester responses, all combinational on the grant.
  always_comb begin
    o_s_addr    = '0;
    o_s_be      = '0;
    o_s_wr_data = '0;
    o_s_wr_en   = 1'b0;
    o_s_rd_en   = 1'b0;
    if (gnt0) begin
      o_s_addr    = i_m0_addr;
      o_s_be      = i_m0_be;
      o_s_wr_data = i_m0_wr_data;
      o_s_wr_en   = i_m0_wr_en & ~to_hit;
      o_s_rd_en   = i_m0_rd_en & ~to_hit;
    end else if (gnt1) begin
      o_s_addr    = i_m1_addr;
      o_s_be      = i_m1_be;
      o_s_wr_data = i_m1_wr_data;
      o_s_wr_en   = i_m1_wr_en & ~to_hit;
      o_s_rd_en   = i_m1_rd_en & ~to_hit;
    end
    o_m0_ack     = gnt0 & (i_s_ack | to_hit);
    o_m1_ack     = gnt1 & (i_s_ack | to_hit);
    o_m0_busy    = i_rst_n & (gnt0 ? i_s_busy : req0);
    o_m1_busy    = i_rst_n & (gnt1 ? i_s_busy : req1);
    o_m0_rd_data = (!owner_q && !(gnt0 && to_hit)) ? i_s_rd_data : '0;
    o_m1_rd_data = ( owner_q && !(gnt1 && to_hit)) ? i_s_rd_data : '0;
  end

endmodule

// File: tb/tb_perif_bus_arbiter.sv
// Self-checking bench for perif_bus_arbiter: vector table through a
// scoreboard queue, plus a hand-written asynchronous reset sequence.
// Timeout vectors are included when PERIF_ARB_TIMEOUT_EN is defined.
module tb_perif_bus_arbiter;

`ifdef PERIF_ARB_TIMEOUT_EN
  localparam int unsigned TB_TMO = 4;
`else
  localparam int unsigned TB_TMO = 255;
`endif

  localparam logic [7:0]  M0_ADDR = 8'h01;
  localparam logic [3:0]  M0_BE   = 4'hF;
  localparam logic [31:0] M0_WD   = 32'h0000_00A5;
  localparam logic [7:0]  M1_ADDR = 8'h22;
  localparam logic [3:0]  M1_BE   = 4'h3;
  localparam logic [31:0] M1_WD   = 32'h5555_AAAA;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [9:2]  i_m0_addr, i_m1_addr;
  logic [3:0]  i_m0_be, i_m1_be;
  logic        i_m0_wr_en = 0, i_m0_rd_en = 0, i_m1_wr_en = 0, i_m1_rd_en = 0;
  logic [31:0] i_m0_wr_data, i_m1_wr_data;
  logic [31:0] o_m0_rd_data, o_m1_rd_data;
  logic        o_m0_busy, o_m0_ack, o_m1_busy, o_m1_ack;
  logic        o_m0_err, o_m1_err;
  logic [9:2]  o_s_addr;
  logic [3:0]  o_s_be;
  logic        o_s_wr_en, o_s_rd_en;
  logic [31:0] o_s_wr_data;
  logic [31:0] i_s_rd_data = '0;
  logic        i_s_busy = 0, i_s_ack = 0;

  int checks = 0;
  int errors = 0;

  perif_bus_arbiter #(.p_timeout(TB_TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m0_addr(i_m0_addr), .i_m0_be(i_m0_be), .i_m0_wr_en(i_m0_wr_en),
    .i_m0_rd_en(i_m0_rd_en), .i_m0_wr_data(i_m0_wr_data),
    .o_m0_rd_data(o_m0_rd_data), .o_m0_busy(o_m0_busy), .o_m0_ack(o_m0_ack),
    .i_m1_addr(i_m1_addr), .i_m1_be(i_m1_be), .i_m1_wr_en(i_m1_wr_en),
    .i_m1_rd_en(i_m1_rd_en), .i_m1_wr_data(i_m1_wr_data),
    .o_m1_rd_data(o_m1_rd_data), .o_m1_busy(o_m1_busy), .o_m1_ack(o_m1_ack),
`ifdef PERIF_ARB_TIMEOUT_EN
    .o_m0_err(o_m0_err), .o_m1_err(o_m1_err),
`endif
    .o_s_addr(o_s_addr), .o_s_be(o_s_be), .o_s_wr_en(o_s_wr_en),
    .o_s_wr_data(o_s_wr_data), .o_s_rd_en(o_s_rd_en),
    .i_s_rd_data(i_s_rd_data), .i_s_busy(i_s_busy), .i_s_ack(i_s_ack)
  );

`ifndef PERIF_ARB_TIMEOUT_EN
  assign o_m0_err = 1'b0;
  assign o_m1_err = 1'b0;
`endif

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst, m0w, m0r, m1w, m1r, sack, sbusy;
    logic [31:0] srd;
    logic        e_wr, e_rd, e_chk;
    logic [7:0]  e_addr;
    logic        e_ack0, e_ack1, e_busy0, e_busy1;
    logic [31:0] e_rd0, e_rd1;
    logic        e_err0, e_err1;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t v(
    input logic rst, m0w, m0r, m1w, m1r, sack, sbusy, input logic [31:0] srd,
    input logic wr, rd, chk, input logic [7:0] addr,
    input logic a0, a1, b0, b1, input logic [31:0] rd0, rd1,
    input logic er0, er1);
    vec_t t;
    t.rst = rst; t.m0w = m0w; t.m0r = m0r; t.m1w = m1w; t.m1r = m1r;
    t.sack = sack; t.sbusy = sbusy; t.srd = srd;
    t.e_wr = wr; t.e_rd = rd; t.e_chk = chk; t.e_addr = addr;
    t.e_ack0 = a0; t.e_ack1 = a1; t.e_busy0 = b0; t.e_busy1 = b1;
    t.e_rd0 = rd0; t.e_rd1 = rd1; t.e_err0 = er0; t.e_err1 = er1;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %h exp %h", name, idx, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, then compare outputs half a period later.
  task automatic step(input vec_t t, input int idx);
    vec_t e;
    @(posedge i_clk);
    #1;
    i_rst_n    = ~t.rst;
    i_m0_wr_en = t.m0w; i_m0_rd_en = t.m0r;
    i_m1_wr_en = t.m1w; i_m1_rd_en = t.m1r;
    i_s_ack    = t.sack; i_s_busy = t.sbusy; i_s_rd_data = t.srd;
    sb.push_back(t);
    @(negedge i_clk);
    e = sb.pop_front();
    chk("s_wr_en", idx, 32'(o_s_wr_en), 32'(e.e_wr));
    chk("s_rd_en", idx, 32'(o_s_rd_en), 32'(e.e_rd));
    if (e.e_chk) begin
      chk("s_addr", idx, 32'(o_s_addr), 32'(e.e_addr));
      chk("s_wr_data", idx, o_s_wr_data,
          e.e_addr == M0_ADDR ? M0_WD : e.e_addr == M1_ADDR ? M1_WD : 32'h0);
      chk("s_be", idx, 32'(o_s_be),
          32'(e.e_addr == M0_ADDR ? M0_BE : e.e_addr == M1_ADDR ? M1_BE : 4'h0));
    end
    chk("m0_ack", idx, 32'(o_m0_ack), 32'(e.e_ack0));
    chk("m1_ack", idx, 32'(o_m1_ack), 32'(e.e_ack1));
    chk("m0_busy", idx, 32'(o_m0_busy), 32'(e.e_busy0));
    chk("m1_busy", idx, 32'(o_m1_busy), 32'(e.e_busy1));
    chk("m0_rd_data", idx, o_m0_rd_data, e.e_rd0);
    chk("m1_rd_data", idx, o_m1_rd_data, e.e_rd1);
`ifdef PERIF_ARB_TIMEOUT_EN
    chk("m0_err", idx, 32'(o_m0_err), 32'(e.e_err0));
    chk("m1_err", idx, 32'(o_m1_err), 32'(e.e_err1));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_m0_addr = M0_ADDR; i_m0_be = M0_BE; i_m0_wr_data = M0_WD;
    i_m1_addr = M1_ADDR; i_m1_be = M1_BE; i_m1_wr_data = M1_WD;

    // rst m0w m0r m1w m1r ack busy srd | wr rd chk addr a0 a1 b0 b1 rd0 rd1 er0 er1
    // Simultaneous reads from reset, handover, owner steering, request drop.
    vecs.push_back(v(1,0,1,0,0,0,0,0,            0,0,1,8'h00,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,1,0,1,0,0,0,            0,0,1,8'h00,0,0,1,1,0,0,0,0));
    vecs.push_back(v(0,0,1,0,1,0,1,0,            0,1,1,8'h01,0,0,1,1,0,0,0,0));
    vecs.push_back(v(0,0,1,0,1,1,0,0,            0,1,1,8'h01,1,0,0,1,0,0,0,0));
    vecs.push_back(v(0,0,1,0,1,1,0,32'hDEAD0001, 0,1,1,8'h22,0,1,1,0,0,32'hDEAD0001,0,0));
    vecs.push_back(v(0,0,1,0,0,0,0,32'hCAFE0002, 0,1,1,8'h01,0,0,0,0,32'hCAFE0002,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,            0,0,1,8'h01,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,32'h11,       0,0,1,8'h00,0,0,0,0,32'h11,0,0,0));
    // m0 single write acked on the second grant cycle.
    vecs.push_back(v(1,0,0,0,0,0,0,0,            0,0,1,8'h00,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,1,0,0,0,0,0,0,            0,0,1,8'h00,0,0,1,0,0,0,0,0));
    vecs.push_back(v(0,1,0,0,0,0,0,0,            1,0,1,8'h01,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,1,0,0,0,1,0,0,            1,0,1,8'h01,1,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,            0,0,0,8'h00,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,            0,0,1,8'h00,0,0,0,0,0,0,0,0));
    // m1 read with data returned one cycle after ack.
    vecs.push_back(v(1,0,0,0,0,0,0,0,            0,0,1,8'h00,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,1,0,0,0,            0,0,1,8'h00,0,0,0,1,0,0,0,0));
    vecs.push_back(v(0,0,0,0,1,1,0,0,            0,1,1,8'h22,0,1,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,32'h12345678, 0,0,0,8'h00,0,0,0,0,0,32'h12345678,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,            0,0,1,8'h00,0,0,0,0,0,0,0,0));
    // Continuous requests from both: six alternating transfers.
    vecs.push_back(v(1,0,0,0,0,0,0,0,            0,0,1,8'h00,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,1,0,1,0,0,0,            0,0,1,8'h00,0,0,1,1,0,0,0,0));
    for (int unsigned k = 0; k < 3; k++) begin
      vecs.push_back(v(0,0,1,0,1,1,0,0,          0,1,1,8'h01,1,0,0,1,0,0,0,0));
      vecs.push_back(v(0,0,1,0,1,1,0,0,          0,1,1,8'h22,0,1,1,0,0,0,0,0));
    end
    vecs.push_back(v(0,0,0,0,0,0,0,0,            0,0,1,8'h01,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,            0,0,1,8'h00,0,0,0,0,0,0,0,0));
`ifdef PERIF_ARB_TIMEOUT_EN
    // Slave never acks m0: forced ack+err on the fourth grant cycle.
    vecs.push_back(v(1,0,0,0,0,0,0,0,            0,0,1,8'h00,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,1,0,0,0,0,0,            0,0,1,8'h00,0,0,1,0,0,0,0,0));
    for (int unsigned k = 0; k < 3; k++)
      vecs.push_back(v(0,0,1,0,0,0,0,32'h77,     0,1,1,8'h01,0,0,0,0,32'h77,0,0,0));
    vecs.push_back(v(0,0,1,0,0,0,0,32'hBEEF,     0,0,1,8'h01,1,0,0,0,0,0,1,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,            0,0,0,8'h00,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,            0,0,1,8'h00,0,0,0,0,0,0,0,0));
`endif
    // Lead-in for the asynchronous reset sequence: end mid-grant of m1.
    vecs.push_back(v(1,0,0,0,0,0,0,0,            0,0,1,8'h00,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,1,0,1,0,0,0,            0,0,1,8'h00,0,0,1,1,0,0,0,0));
    vecs.push_back(v(0,0,1,0,1,1,0,0,            0,1,1,8'h01,1,0,0,1,0,0,0,0));
    vecs.push_back(v(0,0,1,0,1,0,0,0,            0,1,1,8'h22,0,0,1,0,0,0,0,0));

    foreach (vecs[i]) step(vecs[i], i);

    // Reset pulse between clock edges while m1 holds the grant.
    #1 i_rst_n = 1'b0;
    #1;
    chk("arst_rd_en", 100, 32'(o_s_rd_en), 32'd0);
    chk("arst_addr", 100, 32'(o_s_addr), 32'd0);
    chk("arst_busy0", 100, 32'(o_m0_busy), 32'd0);
    chk("arst_busy1", 100, 32'(o_m1_busy), 32'd0);
    chk("arst_ack1", 100, 32'(o_m1_ack), 32'd0);
    #1 i_rst_n = 1'b1;
    #1;
    chk("arst_rel_rd_en", 101, 32'(o_s_rd_en), 32'd0);
    chk("arst_rel_busy0", 101, 32'(o_m0_busy), 32'd1);
    // Both still requesting: pointer back at 1 so m0 wins.
    @(posedge i_clk);
    @(negedge i_clk);
    chk("arst_regrant_addr", 102, 32'(o_s_addr), 32'(M0_ADDR));
    chk("arst_regrant_rd_en", 102, 32'(o_s_rd_en), 32'd1);
    chk("arst_regrant_busy1", 102, 32'(o_m1_busy), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
